// File: rtl/scandoubler_rotate_arb_if.sv
// Bus bundle for the rotation scandoubler SDRAM scheduler: video-in write
// stream, video-out read stream and the single 8-word-burst memory port.
interface scandoubler_rotate_arb_if #(
  parameter int HCNT_WIDTH = 10,
  parameter int ADDR_WIDTH = 22
);
  logic                  vidin_req;
  logic [1:0]            vidin_frame;
  logic [HCNT_WIDTH-1:0] vidin_x;
  logic [HCNT_WIDTH-1:0] vidin_y;
  logic [15:0]           vidin_d;
  logic                  vidin_ack;

  logic                  vidout_req;
  logic [1:0]            vidout_frame;
  logic [HCNT_WIDTH-1:0] vidout_x;
  logic [HCNT_WIDTH-1:0] vidout_y;
  logic [15:0]           vidout_d;
  logic                  vidout_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_ack;
  logic [15:0]           mem_rdata;
  logic                  mem_rvalid;
  logic                  burst_err;

  // master: the scheduler, which owns the memory port
  modport master (
    input  vidin_req, vidin_frame, vidin_x, vidin_y, vidin_d,
    output vidin_ack,
    input  vidout_req, vidout_frame, vidout_x, vidout_y,
    output vidout_d, vidout_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, burst_err,
    input  mem_ack, mem_rdata, mem_rvalid
  );

  modport slave (
    output vidin_req, vidin_frame, vidin_x, vidin_y, vidin_d,
    input  vidin_ack,
    output vidout_req, vidout_frame, vidout_x, vidout_y,
    input  vidout_d, vidout_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, burst_err,
    output mem_ack, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/scandoubler_rotate_arb.sv
// Single-port SDRAM burst scheduler for the rotation scandoubler (read-favoured,
// starvation-bounded). Optional stall watchdog: define ROTATE_ARB_TIMEOUT_EN.
module scandoubler_rotate_arb #(
  parameter int HCNT_WIDTH   = 10,
  parameter int ADDR_WIDTH   = 22,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 255
) (
  input logic                      clk_sys,
  input logic                      reset,
  scandoubler_rotate_arb_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int              SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam int              BW         = 2 + 2 * HCNT_WIDTH;

  logic [1:0]            state;
  logic [2:0]            word_cnt;
  logic [SW-1:0]         starve_cnt;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  vidout_ack_q;
  logic [15:0]           vidout_d_q;

  logic                  grant_wr, grant_rd;
  logic                  busy, hs, abort;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  // Bursts are 8-word aligned, so the low x bits never reach the address.
  logic unused_xlo;
  assign unused_xlo = ^{bus.vidin_x[2:0], bus.vidout_x[2:0]};

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    wr_addr[BW-1:0] = {bus.vidin_frame,  bus.vidin_y,  bus.vidin_x[HCNT_WIDTH-1:3],  3'b000};
    rd_addr[BW-1:0] = {bus.vidout_frame, bus.vidout_y, bus.vidout_x[HCNT_WIDTH-1:3], 3'b000};
  end

  // Read wins unless the writer has already lost STARVE_LIMIT grants in a row.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == S_IDLE) begin
      if (bus.vidout_req && !(bus.vidin_req && starve_cnt == STARVE_MAX))
        grant_rd = 1'b1;
      else if (bus.vidin_req)
        grant_wr = 1'b1;
    end
  end

  assign busy = (state == S_WR) || (state == S_RD);
  assign hs   = ((state == S_WR) && bus.mem_ack) || ((state == S_RD) && bus.mem_rvalid);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      starve_cnt   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      vidout_ack_q <= 1'b0;
      vidout_d_q   <= '0;
    end else begin
      vidout_ack_q <= (state == S_RD) && bus.mem_rvalid;
      if ((state == S_RD) && bus.mem_rvalid)
        vidout_d_q <= bus.mem_rdata;

      case (state)
        S_IDLE: begin
          word_cnt <= '0;
          if (grant_rd) begin
            state      <= S_RD;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= rd_addr;
            if (bus.vidin_req && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_wr) begin
            state      <= S_WR;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_addr;
            starve_cnt <= '0;
          end
        end
        S_WR: begin
          if (bus.mem_ack) begin
            word_cnt <= word_cnt + 3'd1;
            if (word_cnt == 3'd7) begin
              mem_req_q <= 1'b0;
              state     <= S_GAP;
            end
          end
        end
        S_RD: begin
          // The controller latches the request once data starts flowing.
          if (bus.mem_rvalid) begin
            word_cnt  <= word_cnt + 3'd1;
            mem_req_q <= 1'b0;
            if (word_cnt == 3'd7)
              state <= S_GAP;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (abort) begin
        state     <= S_GAP;
        mem_req_q <= 1'b0;
        word_cnt  <= '0;
      end
    end
  end

`ifdef ROTATE_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] idle_cnt;
  logic       err_q;

  // Abort on the TIMEOUT-th consecutive cycle without a handshake.
  assign abort = busy && !hs && (idle_cnt == TO_LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else if (!busy || hs) begin
      idle_cnt <= '0;
    end else if (abort) begin
      idle_cnt <= '0;
      err_q    <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign bus.burst_err = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_busy;
  assign unused_busy   = busy ^ hs;
  assign abort         = 1'b0;
  assign bus.burst_err = 1'b0;
`endif

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = bus.vidin_d;
  assign bus.vidin_ack  = (state == S_WR) && bus.mem_ack;
  assign bus.vidout_ack = vidout_ack_q;
  assign bus.vidout_d   = vidout_d_q;
endmodule

// File: tb/tb_scandoubler_rotate_arb.sv
// Directed bench for scandoubler_rotate_arb: table of grant/address vectors
// plus hand-written drop, reset-mid-burst and (optional) timeout sequences.
module tb_scandoubler_rotate_arb;
  localparam int HW = 10;
  localparam int AW = 22;
  localparam int SL = 3;
  localparam int TO = 16;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  scandoubler_rotate_arb_if #(.HCNT_WIDTH(HW), .ADDR_WIDTH(AW)) bus ();

  scandoubler_rotate_arb #(
    .HCNT_WIDTH(HW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit              win;
    bit              rin;
    logic [1:0]      wf;
    logic [HW-1:0]   wx;
    logic [HW-1:0]   wy;
    logic [1:0]      rf;
    logic [HW-1:0]   rx;
    logic [HW-1:0]   ry;
    bit              exp_we;
    logic [AW-1:0]   exp_addr;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    int k;
    k = 0;
    while (bus.mem_req !== 1'b1 && k < 20) begin
      @(posedge clk_sys); #1;
      k++;
    end
    check({tag, "_grant"}, {31'd0, bus.mem_req}, 32'd1);
  endtask

  // Runs one full burst from the requester's side; returns in the GAP cycle.
  task automatic do_burst(input bit exp_we, input logic [AW-1:0] exp_addr,
                          input int drop_after, input string tag);
    int k, nack, nrv, derr;
    logic [15:0] wd;
    wait_grant(tag);
    check({tag, "_we"},   {31'd0, bus.mem_we}, {31'd0, exp_we});
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
    nack = 0; nrv = 0; derr = 0;
    if (exp_we) begin
      for (k = 0; k < 20 && bus.mem_req === 1'b1; k++) begin
        wd = 16'hA000 + 16'(k);
        bus.vidin_d = wd;
        bus.mem_ack = 1'b1;
        #1;
        if (bus.vidin_ack === 1'b1) nack++;
        if (bus.mem_wdata !== wd) derr++;
        @(posedge clk_sys); #1;
      end
      // Stray ack while in GAP must be ignored.
      bus.mem_ack = 1'b1;
      #1;
      check({tag, "_gap_ack"}, {31'd0, bus.vidin_ack}, 32'd0);
      bus.mem_ack = 1'b0;
    end else begin
      for (k = 0; k < 40 && nack < 8; k++) begin
        if (bus.vidout_ack === 1'b1) begin
          if (bus.vidout_d !== 16'h5000 + 16'(nack)) derr++;
          nack++;
        end
        if (k >= 4 && nrv < 8) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 16'h5000 + 16'(nrv);
          nrv++;
          if (nrv == drop_after) bus.vidout_req = 1'b0;
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = 16'hDEAD;
        end
        if (nack < 8) begin
          @(posedge clk_sys); #1;
        end
      end
      bus.mem_rvalid = 1'b0;
    end
    check({tag, "_acks"}, nack, 8);
    check({tag, "_data"}, derr, 0);
    check({tag, "_req_done"}, {31'd0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    // win rin  wf    wx      wy      rf    rx      ry      we  addr
    vt[0] = '{1'b1, 1'b0, 2'd1, 10'h025, 10'h007, 2'd0, 10'h000, 10'h000, 1'b1, 22'h101C20};
    vt[1] = '{1'b0, 1'b1, 2'd0, 10'h000, 10'h000, 2'd2, 10'h000, 10'h003, 1'b0, 22'h200C00};
    vt[2] = '{1'b1, 1'b1, 2'd3, 10'h3FF, 10'h3FF, 2'd0, 10'h010, 10'h001, 1'b0, 22'h000410};
    vt[3] = '{1'b1, 1'b1, 2'd3, 10'h3FF, 10'h3FF, 2'd0, 10'h010, 10'h001, 1'b0, 22'h000410};
    vt[4] = '{1'b1, 1'b1, 2'd3, 10'h3FF, 10'h3FF, 2'd0, 10'h010, 10'h001, 1'b0, 22'h000410};
    vt[5] = '{1'b1, 1'b1, 2'd3, 10'h3FF, 10'h3FF, 2'd0, 10'h010, 10'h001, 1'b1, 22'h3FFFF8};
    vt[6] = '{1'b1, 1'b1, 2'd3, 10'h3FF, 10'h3FF, 2'd0, 10'h010, 10'h001, 1'b0, 22'h000410};

    reset = 1'b0;
    bus.vidin_req = 1'b0; bus.vidin_frame = '0; bus.vidin_x = '0; bus.vidin_y = '0; bus.vidin_d = '0;
    bus.vidout_req = 1'b0; bus.vidout_frame = '0; bus.vidout_x = '0; bus.vidout_y = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_mem_req",    {31'd0, bus.mem_req},    32'd0);
    check("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),       32'd0);
    check("rst_vidout_ack", {31'd0, bus.vidout_ack}, 32'd0);
    check("rst_vidout_d",   32'(bus.vidout_d),       32'd0);
    check("rst_burst_err",  {31'd0, bus.burst_err},  32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.vidin_req  = vt[i].win;  bus.vidin_frame  = vt[i].wf; bus.vidin_x  = vt[i].wx; bus.vidin_y  = vt[i].wy;
      bus.vidout_req = vt[i].rin;  bus.vidout_frame = vt[i].rf; bus.vidout_x = vt[i].rx; bus.vidout_y = vt[i].ry;
      do_burst(vt[i].exp_we, vt[i].exp_addr, 0, $sformatf("vec%0d", i));
    end
    bus.vidin_req = 1'b0;
    bus.vidout_req = 1'b0;

    // Read requester walks away mid-burst: all 8 words still delivered.
    repeat (2) @(posedge clk_sys);
    #1;
    bus.vidout_req = 1'b1; bus.vidout_frame = 2'd0; bus.vidout_x = 10'h048; bus.vidout_y = 10'h002;
    do_burst(1'b0, 22'h000848, 2, "drop");
    repeat (4) @(posedge clk_sys);
    #1;
    check("drop_idle_req", {31'd0, bus.mem_req},    32'd0);
    check("drop_idle_ack", {31'd0, bus.vidout_ack}, 32'd0);

    // Reset during word 4 of a write burst, then a clean burst.
    bus.vidin_req = 1'b1; bus.vidin_frame = 2'd0; bus.vidin_x = 10'h008; bus.vidin_y = 10'h000;
    wait_grant("rstmid");
    for (int k = 0; k < 3; k++) begin
      bus.mem_ack = 1'b1;
      @(posedge clk_sys); #1;
    end
    bus.mem_ack = 1'b1;
    #1;
    check("rstmid_w4_ack", {31'd0, bus.vidin_ack}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_ack",  {31'd0, bus.vidin_ack}, 32'd0);
    check("rstmid_req",  {31'd0, bus.mem_req},   32'd0);
    check("rstmid_we",   {31'd0, bus.mem_we},    32'd0);
    check("rstmid_addr", 32'(bus.mem_addr),      32'd0);
    bus.mem_ack = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    do_burst(1'b1, 22'h000008, 0, "postrst");
    bus.vidin_req = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;

`ifdef ROTATE_ARB_TIMEOUT_EN
    begin
      int idle;
      bus.vidin_req = 1'b1; bus.vidin_frame = 2'd2; bus.vidin_x = 10'h000; bus.vidin_y = 10'h000;
      wait_grant("tmo");
      bus.vidin_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
        bus.mem_ack = 1'b1;
        @(posedge clk_sys); #1;
      end
      bus.mem_ack = 1'b0;
      idle = 0;
      while (bus.mem_req === 1'b1 && idle < 40) begin
        @(posedge clk_sys); #1;
        idle++;
      end
      check("tmo_cycles", idle, TO);
      check("tmo_err",    {31'd0, bus.burst_err}, 32'd1);
      repeat (2) @(posedge clk_sys);
      #1;
      bus.vidout_req = 1'b1; bus.vidout_frame = 2'd1; bus.vidout_x = 10'h000; bus.vidout_y = 10'h000;
      do_burst(1'b0, 22'h100000, 0, "tmo_next");
      bus.vidout_req = 1'b0;
      check("tmo_err_sticky", {31'd0, bus.burst_err}, 32'd1);
    end
`else
    check("no_tmo_err", {31'd0, bus.burst_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scandoubler_rotate_arb.md
Name: scandoubler_rotate_arb

Overview:
- Single-port SDRAM burst scheduler for the rotation scandoubler.
- Shares one 8-word-burst memory port between two requesters:
  - the video-in write stream (rotated pixel columns/rows);
  - the video-out read stream (linebuffer prefetch).
- Builds the linear burst address from frame/x/y, counts words and turns the memory handshake into per-requester acks.
- Read is favoured (output deadline); a starvation limit guarantees write progress.

Parameters:
- HCNT_WIDTH, 10, width of x and y coordinates.
- ADDR_WIDTH, 22, width of mem_addr; must be at least 2+2*HCNT_WIDTH.
- STARVE_LIMIT, 3, consecutive read bursts allowed while a write is pending before the write is forced.
- TIMEOUT, 255, idle-handshake cycles before a burst is aborted (only used with the optional feature).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- vidin_req  in  1  write burst request, held until the 8th ack.
- vidin_frame  in  2  write frame.
- vidin_x  in  HCNT_WIDTH  write x.
- vidin_y  in  HCNT_WIDTH  write y.
- vidin_d  in  16  write data.
- vidin_ack  out  1  write word consumed.
- vidout_req  in  1  read request, held for the whole row.
- vidout_frame  in  2  read frame.
- vidout_x  in  HCNT_WIDTH  read x.
- vidout_y  in  HCNT_WIDTH  read y.
- vidout_d  out  16  read data.
- vidout_ack  out  1  read word valid.
- mem_req  out  1  burst request to the SDRAM controller.
- mem_we  out  1  1 means write burst.
- mem_addr  out  ADDR_WIDTH  burst base address, word granularity.
- mem_wdata  out  16  write data.
- mem_ack  in  1  controller accepted one write word.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  read word valid.
- burst_err  out  1  sticky timeout flag.

Behaviour:
- Reset:
  - state is IDLE; word counter and starve counter are 0.
  - mem_req, mem_we, vidin_ack, vidout_ack and burst_err are 0.
  - mem_addr and vidout_d are 0.
  - Reset asserted mid-burst abandons the burst immediately; no completion words are generated.
- States: IDLE, WR, RD, GAP.
- IDLE arbitration, registered, one cycle:
  - read only pending: go to RD.
  - write only pending: go to WR.
  - both pending: RD, unless starve_cnt equals STARVE_LIMIT, in which case WR.
  - neither pending: stay in IDLE.
- Starve counter:
  - starve_cnt increments on each RD grant made while vidin_req=1, saturating at STARVE_LIMIT.
  - it clears on any WR grant.
- On grant, these are registered:
  - mem_addr = zero-extended {frame, y, x[HCNT_WIDTH-1:3], 3'b000};
  - mem_we = 1 for WR, 0 for RD;
  - mem_req = 1.
  - Address low 3 bits are always 0; the incoming x[2:0] (write) is ignored.
- WR:
  - mem_wdata = vidin_d, combinational.
  - vidin_ack = mem_ack, combinational, gated by state==WR.
  - Word counter increments per mem_ack.
  - The 8th ack clears mem_req and moves to GAP.
- RD:
  - vidout_d = mem_rdata; vidout_ack = mem_rvalid (registered, 1-cycle latency), gated by state==RD.
  - The 8th rvalid moves to GAP; mem_req clears on the first rvalid.
- Burst completion: once granted, a burst always completes 8 words even if the requester drops its req mid-burst. Acks still pulse; the requester tolerates the extras.
- GAP:
  - one idle cycle (bus turnaround / requester address update), then IDLE.
  - Back-to-back reads therefore cost 2 cycles of overhead per burst.
- Acks outside WR/RD are 0. mem_ack or mem_rvalid arriving in the wrong state is ignored.
- Word counter is 3 bits; it wraps to 0 at the end of each burst.

Optional Feature:
- Macro: ROTATE_ARB_TIMEOUT_EN.
- With the macro:
  - an 8-bit idle counter runs in WR/RD and clears on every mem_ack or mem_rvalid.
  - reaching TIMEOUT forces GAP, clears mem_req and sets burst_err.
  - burst_err stays set until reset.
- Without the macro: the counter is absent, burst_err is tied 0, and a stalled burst waits forever.

Test Plan:
- Write only: vidin_req=1, frame=1, x=0x25, y=7, mem_ack every cycle.
  -> mem_we=1; mem_addr = {1, 7, 0x20}; 8 vidin_ack pulses; mem_req drops after the 8th; GAP, then IDLE.
- Read only: vidout_req held, x=0, y=3, rvalid after 4-cycle latency.
  -> 8 vidout_ack pulses, each one cycle after rvalid; vidout_d matches mem_rdata.
- Simultaneous requests, STARVE_LIMIT=3, both held.
  -> grant order RD, RD, RD, WR, RD...; starve_cnt is 0 after the WR.
- vidout_req dropped after the 2nd rvalid.
  -> burst still returns 8 vidout_ack pulses, then IDLE.
- Reset pulsed during word 4 of a write burst.
  -> all outputs 0 asynchronously; the next burst starts cleanly with word count 0.
- With ROTATE_ARB_TIMEOUT_EN, TIMEOUT=16, mem_ack withheld after word 2.
  -> after 16 cycles mem_req=0, burst_err=1 (sticky); the next request is served normally.
